// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass filter chain (lpf_avg and lpf_decim).
// Holds the common sample width, the signed sample type and the
// decimator's FILL/RUN state encoding.
package lpf_pkg;

  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;

  // FILL: discarding the filter's start-up transient.
  // RUN:  decimating and buffering samples.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   push, din - write request and data (accepted when not full, or when
//               a pop happens in the same cycle)
//   pop       - read request (ignored while empty)
//   dout      - head entry while non-empty, zero while empty
//   level     - number of stored entries (0..DEPTH)
//   full      - level == DEPTH
//   empty     - level == 0
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // without a separate counter; the low AW bits index the storage.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lpf_decim.sv
// Post-filter decimator for the lpf_avg output stream.
// Discards the first SKIP valid samples after reset (window fill-up
// transient), then keeps one valid sample in every DECIM and buffers the
// kept samples in a FIFO presented on a valid/ready port.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   x_in, x_valid     - input sample stream from the filter
//   m_data, m_valid   - buffered output sample (zero while not valid)
//   m_ready           - consumer accepts m_data this cycle
//   level             - current FIFO occupancy
//   overflow          - sticky: a kept sample was dropped on a full FIFO
module lpf_decim
  import lpf_pkg::*;
#(
  parameter int DATA_W = lpf_pkg::DATA_W,
  parameter int DECIM  = 4,
  parameter int SKIP   = 7,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       x_in,
  input  logic                    x_valid,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  // With no transient to skip the block starts directly in RUN.
  localparam state_t     INIT_STATE = (SKIP > 0) ? FILL : RUN;
  localparam logic [7:0] SKIP_LAST  = 8'(SKIP - 1);
  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] skip_cnt;
  logic [7:0] phase;
  logic       keep;
  logic       pop;
  logic       full;
  logic       empty;

  assign m_valid = !empty;
  assign pop     = m_ready && m_valid;

  // State register, skip/phase counters and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_STATE;
      skip_cnt <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FILL && x_valid) begin
        skip_cnt <= skip_cnt + 8'd1;
      end
      // Phase only advances on valid samples, so gaps in the input do not
      // disturb the decimation pattern.
      if (state == RUN && x_valid) begin
        phase <= (phase == DECIM_LAST) ? 8'd0 : phase + 8'd1;
      end
      // A simultaneous pop makes room, so only a push-without-pop into a
      // full FIFO loses data.
      if (keep && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Next-state and keep decision. The last skipped sample moves to RUN with
  // phase still 0, so the very next valid sample is kept.
  always_comb begin
    next_state = state;
    keep       = 1'b0;
    case (state)
      FILL: begin
        if (x_valid && skip_cnt == SKIP_LAST) next_state = RUN;
      end
      RUN: begin
        if (x_valid && phase == 8'd0) keep = 1'b1;
      end
      default: next_state = INIT_STATE;
    endcase
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (pop),
    .din   (x_in),
    .dout  (m_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_lpf_decim.sv
// Testbench for lpf_decim. Three instances cover the default configuration
// (DECIM=4, SKIP=7), a gapped-input configuration (DECIM=3, SKIP=2) and a
// passthrough configuration (DECIM=1, SKIP=0). A queue-style reference model
// tracks the expected outputs from the keep/drop rules directly.
module tb_lpf_decim;

  localparam int N     = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_valid  [N];
  logic        m_valid  [N];
  logic        m_ready  [N];
  logic        overflow [N];
  logic [15:0] x_in     [N];
  logic [15:0] m_data   [N];
  logic [3:0]  level    [N];

  int errors = 0;
  int checks = 0;

  // Reference model: count of valid samples since reset, an ordered list of
  // buffered samples, and the sticky drop flag.
  int          acc  [N];
  int          mcnt [N];
  logic [15:0] marr [N][DEPTH];
  logic        movf [N];
  int          popped[$];

  always #5 clk = ~clk;

  lpf_decim #(.DATA_W(16), .DECIM(4), .SKIP(7), .DEPTH(DEPTH)) u_def (
    .clk(clk), .rst(rst), .x_in(x_in[0]), .x_valid(x_valid[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .level(level[0]), .overflow(overflow[0]));

  lpf_decim #(.DATA_W(16), .DECIM(3), .SKIP(2), .DEPTH(DEPTH)) u_gap (
    .clk(clk), .rst(rst), .x_in(x_in[1]), .x_valid(x_valid[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .level(level[1]), .overflow(overflow[1]));

  lpf_decim #(.DATA_W(16), .DECIM(1), .SKIP(0), .DEPTH(DEPTH)) u_pass (
    .clk(clk), .rst(rst), .x_in(x_in[2]), .x_valid(x_valid[2]),
    .m_data(m_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .level(level[2]), .overflow(overflow[2]));

  function automatic int decim_of(int k);
    case (k)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int skip_of(int k);
    case (k)
      0:       return 7;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  // Packed {valid, data, level, overflow} expected from the model.
  function automatic logic [21:0] expect_out(int k);
    logic        v;
    logic [15:0] d;
    v = (mcnt[k] > 0);
    d = v ? marr[k][0] : 16'd0;
    return {v, d, 4'(mcnt[k]), movf[k]};
  endfunction

  function automatic logic [21:0] actual_out(int k);
    return {m_valid[k], m_data[k], level[k], overflow[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      acc[k]  = 0;
      mcnt[k] = 0;
      movf[k] = 1'b0;
    end
  endtask

  // One clock edge of the reference model for instance k.
  task automatic model_edge(int k, logic v, logic [15:0] d, logic rdy);
    bit keep;
    keep = 0;
    if (v) begin
      acc[k]++;
      if (acc[k] > skip_of(k) && ((acc[k] - skip_of(k) - 1) % decim_of(k)) == 0) keep = 1;
    end
    if (rdy && mcnt[k] > 0) begin
      for (int j = 0; j < DEPTH - 1; j++) marr[k][j] = marr[k][j+1];
      mcnt[k]--;
    end
    if (keep) begin
      if (mcnt[k] < DEPTH) begin
        marr[k][mcnt[k]] = d;
        mcnt[k]++;
      end else begin
        movf[k] = 1'b1;
      end
    end
  endtask

  // Drive one cycle on instance k (others idle), advance the model, and
  // leave time 1 unit after the edge for sampling.
  task automatic step(int k, logic v, logic [15:0] d, logic rdy);
    for (int i = 0; i < N; i++) begin
      x_valid[i] = 1'b0;
      x_in[i]    = 16'd0;
      m_ready[i] = 1'b0;
    end
    x_valid[k] = v;
    x_in[k]    = d;
    m_ready[k] = rdy;
    if (rdy && m_valid[k]) popped.push_back(int'($signed(m_data[k])));
    @(posedge clk);
    model_edge(k, v, d, rdy);
    #1;
  endtask

  task automatic do_reset(logic v_during);
    for (int i = 0; i < N; i++) begin
      x_valid[i] = v_during;
      x_in[i]    = 16'd99;
      m_ready[i] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    popped.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (actual_out(k) !== 22'd0) begin
        errors++;
        $display("[TB] FAIL reset_state inst=%0d: actual=%h required=%h", k, actual_out(k), 22'd0);
      end
    end
  endtask

  task automatic test_ramp();
    do_reset(1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(0, 1'b1, 16'(i), 1'b1);
      checks++;
      if (actual_out(0) !== expect_out(0)) begin
        errors++;
        $display("[TB] FAIL ramp_model i=%0d: actual=%h required=%h", i, actual_out(0), expect_out(0));
      end
      if (i >= 8 && (i % 4) == 0) begin
        checks++;
        if (m_valid[0] !== 1'b1 || m_data[0] !== 16'(i)) begin
          errors++;
          $display("[TB] FAIL ramp_latency i=%0d: actual v=%b d=%0d required v=1 d=%0d", i, m_valid[0], m_data[0], i);
        end
      end
    end
    for (int i = 0; i < 3; i++) step(0, 1'b0, 16'd0, 1'b1);
    checks++;
    if (popped.size() != 9) begin
      errors++;
      $display("[TB] FAIL ramp_count: actual=%0d required=9", popped.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (popped[j] != 8 + 4 * j) begin
          errors++;
          $display("[TB] FAIL ramp_order j=%0d: actual=%0d required=%0d", j, popped[j], 8 + 4 * j);
        end
      end
    end
    checks++;
    if (overflow[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ramp_overflow: actual=%b required=0", overflow[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int i = 1; i <= 48; i++) begin
      step(0, 1'b1, 16'(i), 1'b0);
      checks++;
      if (actual_out(0) !== expect_out(0)) begin
        errors++;
        $display("[TB] FAIL bp_model i=%0d: actual=%h required=%h", i, actual_out(0), expect_out(0));
      end
    end
    checks++;
    if (level[0] !== 4'd8 || overflow[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_full: actual level=%0d ovf=%b required level=8 ovf=1", level[0], overflow[0]);
    end
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 16'd0, 1'b1);
      checks++;
      if (actual_out(0) !== expect_out(0)) begin
        errors++;
        $display("[TB] FAIL bp_drain_model c=%0d: actual=%h required=%h", i, actual_out(0), expect_out(0));
      end
    end
    checks++;
    if (popped.size() != 8) begin
      errors++;
      $display("[TB] FAIL bp_drain_count: actual=%0d required=8", popped.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (popped[j] != 8 + 4 * j) begin
          errors++;
          $display("[TB] FAIL bp_drain_order j=%0d: actual=%0d required=%0d", j, popped[j], 8 + 4 * j);
        end
      end
    end
    checks++;
    if (m_valid[0] !== 1'b0 || level[0] !== 4'd0) begin
      errors++;
      $display("[TB] FAIL bp_empty: actual v=%b level=%0d required v=0 level=0", m_valid[0], level[0]);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset(1'b0);
    for (int i = 1; i <= 39; i++) step(0, 1'b1, 16'(i), 1'b0);
    checks++;
    if (level[0] !== 4'd8 || overflow[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fpp_pre: actual level=%0d ovf=%b required level=8 ovf=0", level[0], overflow[0]);
    end
    step(0, 1'b1, 16'd40, 1'b1);
    checks++;
    if (level[0] !== 4'd8 || overflow[0] !== 1'b0 || m_data[0] !== 16'd12) begin
      errors++;
      $display("[TB] FAIL fpp_post: actual level=%0d ovf=%b d=%0d required level=8 ovf=0 d=12",
               level[0], overflow[0], m_data[0]);
    end
    checks++;
    if (actual_out(0) !== expect_out(0)) begin
      errors++;
      $display("[TB] FAIL fpp_model: actual=%h required=%h", actual_out(0), expect_out(0));
    end
  endtask

  task automatic test_gapped();
    int v;
    do_reset(1'b0);
    v = 10;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) begin
        step(1, 1'b1, 16'(v), 1'b1);
        v++;
      end else begin
        step(1, 1'b0, 16'hBEEF, 1'b1);
      end
      checks++;
      if (actual_out(1) !== expect_out(1)) begin
        errors++;
        $display("[TB] FAIL gap_model c=%0d: actual=%h required=%h", c, actual_out(1), expect_out(1));
      end
    end
    for (int i = 0; i < 2; i++) step(1, 1'b0, 16'd0, 1'b1);
    checks++;
    if (popped.size() != 6) begin
      errors++;
      $display("[TB] FAIL gap_count: actual=%0d required=6", popped.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (popped[j] != 12 + 3 * j) begin
          errors++;
          $display("[TB] FAIL gap_order j=%0d: actual=%0d required=%0d", j, popped[j], 12 + 3 * j);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    for (int i = 1; i <= 48; i++) step(0, 1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 16'd0, 1'b1);
    checks++;
    if (level[0] !== 4'd3 || overflow[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pre: actual level=%0d ovf=%b required level=3 ovf=1", level[0], overflow[0]);
    end
    do_reset(1'b1);
    checks++;
    if (actual_out(0) !== 22'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: actual=%h required=%h", actual_out(0), 22'd0);
    end
    for (int i = 1; i <= 7; i++) begin
      step(0, 1'b1, 16'(100 + i), 1'b1);
      checks++;
      if (m_valid[0] !== 1'b0 || level[0] !== 4'd0) begin
        errors++;
        $display("[TB] FAIL mid_skip i=%0d: actual v=%b level=%0d required v=0 level=0", i, m_valid[0], level[0]);
      end
    end
    step(0, 1'b1, 16'd200, 1'b1);
    checks++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== 16'd200) begin
      errors++;
      $display("[TB] FAIL mid_first_keep: actual v=%b d=%0d required v=1 d=200", m_valid[0], m_data[0]);
    end
  endtask

  task automatic test_passthrough();
    logic [15:0] vals [4];
    vals[0] = 16'h8000;
    vals[1] = 16'h7FFF;
    vals[2] = 16'hFFFF;
    vals[3] = 16'h0000;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2, 1'b1, vals[i], 1'b1);
      checks++;
      if (m_valid[2] !== 1'b1 || m_data[2] !== vals[i]) begin
        errors++;
        $display("[TB] FAIL pass_value i=%0d: actual v=%b d=%h required v=1 d=%h", i, m_valid[2], m_data[2], vals[i]);
      end
      checks++;
      if (actual_out(2) !== expect_out(2)) begin
        errors++;
        $display("[TB] FAIL pass_model i=%0d: actual=%h required=%h", i, actual_out(2), expect_out(2));
      end
    end
  endtask

  task automatic test_random();
    int          k;
    logic        v;
    logic        r;
    logic [15:0] d;
    do_reset(1'b0);
    for (int n = 0; n < 900; n++) begin
      k = int'($urandom_range(0, 2));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      step(k, v, d, r);
      checks++;
      if (actual_out(k) !== expect_out(k)) begin
        errors++;
        $display("[TB] FAIL random_model n=%0d inst=%0d: actual=%h required=%h", n, k, actual_out(k), expect_out(k));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      x_valid[i] = 1'b0;
      x_in[i]    = 16'd0;
      m_ready[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_ramp();
    test_backpressure();
    test_full_push_pop();
    test_gapped();
    test_mid_reset();
    test_passthrough();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
